// File: rtl/div_result_stage.sv
// Registered result stage behind the non-restoring divider array.
// It classifies each result (divide-by-zero, overflow, residue check), queues it in a small FIFO and counts residue errors.
module div_result_stage #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_dividend,
  input  logic [1:0]       in_divisor,
  input  logic [2:0]       in_q,
  input  logic [4:0]       in_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_q,
  output logic [4:0]       out_r,
  output logic             out_dz,
  output logic             out_ovf,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef struct packed {
    logic [2:0] q;
    logic [4:0] r;
    logic       dz;
    logic       ovf;
    logic       err;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count;

  logic             push_c;
  logic             pop_c;
  logic             dz_c;
  logic             ovf_c;
  logic [5:0]       prod_sum_c;
  entry_t           new_c;

  // Handshake flags depend on the occupancy register only
  assign in_ready  = (count != OCC_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push_c    = in_valid && in_ready;
  assign pop_c     = out_valid && out_ready;

  // Classify the incoming result; the residue sum q*d + r is evaluated in 6 bits
  always_comb begin
    new_c      = '0;
    dz_c       = (in_divisor == 2'd0);
    ovf_c      = !dz_c && (in_divisor == 2'd1) && in_dividend[3];
    prod_sum_c = 6'(in_q) * 6'(in_divisor) + 6'(in_r[1:0]);
    if (dz_c) begin
      new_c.q  = 3'b111;
      new_c.r  = {1'b0, in_dividend};
      new_c.dz = 1'b1;
    end else begin
      new_c.q   = in_q;
      new_c.r   = in_r;
      new_c.ovf = ovf_c;
      if (!ovf_c) begin
        new_c.err = (in_r[4:2] != 3'd0) ||
                    (in_r[1:0] >= in_divisor) ||
                    (prod_sum_c != {2'b00, in_dividend});
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      err_cnt <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= new_c;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
      // Clear wins over a same-cycle error push; the counter sticks at all-ones
      if (clr_cnt) begin
        err_cnt <= '0;
      end else if (push_c && new_c.err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

  assign out_q   = mem[rd_ptr].q;
  assign out_r   = mem[rd_ptr].r;
  assign out_dz  = mem[rd_ptr].dz;
  assign out_ovf = mem[rd_ptr].ovf;
  assign out_err = mem[rd_ptr].err;

endmodule

// File: doc/div_result_stage.md
# div_result_stage

Registered result stage directly downstream of the combinational non-restoring divider array (4-bit dividend, 2-bit divisor, 3-bit quotient, 5-bit remainder).
- Captures each result with the operands that produced it over a valid/ready handshake.
- Classifies the result as divide-by-zero, quotient overflow, or checked, and flags any result that fails the residue check q*d + r == dividend.
- Buffers results in a small FIFO so the consumer can apply backpressure without stalling the array's producer.

## Interface
- DEPTH, 2, FIFO entries; legal values 2 or 4.
- CNT_W, 8, width of the saturating error counter.

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  producer has a result.
- in_ready  out  1  stage can accept; equals !full and is registered-state only.
- in_dividend  in  4  dividend fed to the divider.
- in_divisor  in  2  divisor fed to the divider.
- in_q  in  3  quotient from the divider.
- in_r  in  5  remainder from the divider.
- out_valid  out  1  head entry present.
- out_ready  in  1  consumer takes the head.
- out_q  out  3  quotient of the head entry.
- out_r  out  5  remainder of the head entry.
- out_dz  out  1  head entry was divide-by-zero.
- out_ovf  out  1  head entry quotient overflowed 3 bits.
- out_err  out  1  head entry failed the residue check.
- err_cnt  out  CNT_W  count of accepted entries with err=1; saturates at all-ones.
- clr_cnt  in  1  synchronous clear of err_cnt.

## Operation
- Push: occurs when in_valid && in_ready. Pop: occurs when out_valid && out_ready.
- Classification is computed combinationally at push and stored with the entry. Each entry is 11 bits: q, r, dz, ovf, err.
  - dz = (in_divisor == 0).
    - Stored q = 3'b111, r = {1'b0, in_dividend}, ovf = 0, err = 0.
    - in_q and in_r are ignored.
  - ovf = !dz && (in_divisor == 1) && in_dividend[3].
    - Raw in_q and in_r are stored; err = 0.
  - Otherwise (checked case), raw in_q and in_r are stored, and err = 1 if any of the following holds:
    - in_r[4:2] != 0;
    - in_r[1:0] >= in_divisor;
    - (in_q * in_divisor + in_r[1:0]) != in_dividend. The sum is evaluated in 6 bits unsigned, with the dividend zero-extended.
- Occupancy state machine (count register):
  - EMPTY (0): push goes to PARTIAL, or to FULL when DEPTH would be reached.
  - PARTIAL: push only increments count; pop only decrements it; push and pop together hold count.
  - FULL (DEPTH): in_ready = 0, so only a pop is possible, which decrements count. A push cannot occur in the same cycle as a pop from FULL.
- Read and write pointers wrap modulo DEPTH. Order is strictly FIFO.
- out_* data is the entry at the read pointer. It is meaningful only while out_valid = 1 and is not checked otherwise.
- err_cnt:
  - Increments by 1 on a push with err = 1 and holds at all-ones.
  - clr_cnt has priority: in a cycle with both clr_cnt and an err push, err_cnt becomes 0.
  - dz and ovf entries never increment err_cnt.

## Timing
- Reset (async assert, synchronous use after deassert):
  - count = 0, pointers = 0, storage = 0, err_cnt = 0.
  - Outputs: out_valid = 0, in_ready = 1, out_q = 0, out_r = 0, and out_dz = out_ovf = out_err = 0.
- Latency: a push at edge N into EMPTY gives out_valid = 1 with that entry's data after edge N. There is no combinational path from in_* to out_*.
- Throughput: one push and one pop per cycle when count is between 1 and DEPTH-1.
- in_ready and out_valid depend only on count, never on in_valid or out_ready in the same cycle.
- Holding in_valid while in_ready = 0 must not change any state.
- Reset asserted mid-operation: all entries are discarded immediately, with no completion of in-flight handshakes.

## Test plan
- Reset mid-stream: load 2 entries with out_ready = 0, then pulse rst_n low between edges → out_valid = 0, in_ready = 1, err_cnt = 0 immediately, with no clock edge needed.
- Checked pass: dividend 11, divisor 3, q 3, r 5'd2 → one cycle later out_q = 3, out_r = 2, dz = ovf = err = 0; err_cnt unchanged.
- Checked fail: dividend 11, divisor 3, q 2, r 5'd5 → err = 1 and err_cnt = 1. Then assert clr_cnt together with another failing push → err_cnt = 0.
- Divide-by-zero and overflow:
  - dividend 9, divisor 0, q 5, r 1 → out_q = 7, out_r = 9, dz = 1, err = 0.
  - dividend 12, divisor 1, q 4, r 0 → ovf = 1, out_q = 4, err = 0.
- Backpressure (DEPTH = 2): with out_ready = 0, offer A, B, C back-to-back → A and B are accepted, in_ready = 0 after B, and C is held. Release out_ready → A, B, C emerge in order. A simultaneous push and pop at count 1 keeps count at 1.
- err_cnt saturation (CNT_W = 2): 5 failing pushes → err_cnt = 3 and stays at 3.
